// File: rtl/muldiv_pkg.sv
// Shared RV32M opcode map and state encoding for the multiply/divide unit.
package muldiv_pkg;

    localparam logic [4:0] ALU_MUL    = 5'b01110;
    localparam logic [4:0] ALU_MULH   = 5'b01111;
    localparam logic [4:0] ALU_MULHSU = 5'b10000;
    localparam logic [4:0] ALU_MULHU  = 5'b10001;
    localparam logic [4:0] ALU_DIV    = 5'b10010;
    localparam logic [4:0] ALU_DIVU   = 5'b10011;
    localparam logic [4:0] ALU_REM    = 5'b10100;
    localparam logic [4:0] ALU_REMU   = 5'b10101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

    function automatic logic is_m_op(input logic [4:0] c);
        return c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul_op(input logic [4:0] c);
        return c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring shift-subtract iteration on magnitude operands.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nx,
    output logic [XLEN-1:0] quot_nx
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] dvs;
    logic          ge;

    always_comb begin
        rem_sh  = {rem, quot[XLEN-1]};
        dvs     = {1'b0, divisor};
        ge      = (rem_sh >= dvs);
        rem_nx  = ge ? XLEN'(rem_sh - dvs) : rem_sh[XLEN-1:0];
        quot_nx = {quot[XLEN-2:0], ge};
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage unit: one-pass multiply, 32-step restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state;
    logic [CW-1:0]   cnt;
    logic [4:0]      op;
    logic [XLEN:0]   op_a;
    logic [XLEN:0]   op_b;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic            q_neg;
    logic            r_neg;

    logic            sgn_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div0;
    logic            ovf;
    logic            a_sx;
    logic            b_sx;

    always_comb begin
        sgn_div = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_REM);
        a_neg   = sgn_div & src_a[XLEN-1];
        b_neg   = sgn_div & src_b[XLEN-1];
        abs_a   = a_neg ? -src_a : src_a;
        abs_b   = b_neg ? -src_b : src_b;
        div0    = (src_b == '0);
        ovf     = sgn_div && (src_a == INT_MIN) && (src_b == '1);
        a_sx    = (alu_ctrl == ALU_MULH) || (alu_ctrl == ALU_MULHSU);
        b_sx    = (alu_ctrl == ALU_MULH);
    end

    // Sign-extend both 33-bit operands so a plain 64-bit product is exact.
    logic [2*XLEN-1:0] m_a;
    logic [2*XLEN-1:0] m_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        m_a     = {{(XLEN-1){op_a[XLEN]}}, op_a};
        m_b     = {{(XLEN-1){op_b[XLEN]}}, op_b};
        prod    = m_a * m_b;
        mul_res = (op == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] fix_res;

    div_step #(.XLEN(XLEN)) u_step (
        .rem     (rem),
        .quot    (quot),
        .divisor (op_b[XLEN-1:0]),
        .rem_nx  (rem_nx),
        .quot_nx (quot_nx)
    );

    always_comb begin
        fix_res = '0;
        unique case (1'b1)
            (op == ALU_DIV) || (op == ALU_DIVU): fix_res = q_neg ? -quot : quot;
            default:                             fix_res = r_neg ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            quot   <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && is_m_op(alu_ctrl)) begin
                            op  <= alu_ctrl;
                            cnt <= '0;
                            if (is_mul_op(alu_ctrl)) begin
                                op_a  <= {a_sx & src_a[XLEN-1], src_a};
                                op_b  <= {b_sx & src_b[XLEN-1], src_b};
                                state <= MUL;
                            end else begin
                                op_b <= {1'b0, abs_b};
                                unique case (1'b1)
                                    div0: begin
                                        quot  <= '1;
                                        rem   <= src_a;
                                        q_neg <= 1'b0;
                                        r_neg <= 1'b0;
                                        state <= FIX;
                                    end
                                    ovf: begin
                                        quot  <= INT_MIN;
                                        rem   <= '0;
                                        q_neg <= 1'b0;
                                        r_neg <= 1'b0;
                                        state <= FIX;
                                    end
                                    default: begin
                                        quot  <= abs_a;
                                        rem   <= '0;
                                        q_neg <= a_neg ^ b_neg;
                                        r_neg <= a_neg;
                                        state <= DIV;
                                    end
                                endcase
                            end
                        end
                    end
                    MUL: begin
                        result <= mul_res;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                    DIV: begin
                        rem  <= rem_nx;
                        quot <= quot_nx;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) state <= FIX;
                    end
                    FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        kill;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_err = 0;
    int          edges;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res;
    logic        seen;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .kill     (kill),
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = c;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
    endtask

    task automatic issue(input string tag, input logic [4:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
        exp_q.push_back(e);
        lat_q.push_back(lat);
        accept(c, a, b);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] e;
        int          l;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_res"}, result, e);
        chk({tag, "_lat"}, 32'(edges), 32'(l));
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        last_res = e;
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [4:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat);
        issue(tag, c, a, b, e, lat);
        wait_done(tag);
        pulse_end(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        kill     = 1'b0;
        alu_ctrl = '0;
        src_a    = '0;
        src_b    = '0;
        last_res = '0;
        edges    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_res", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run("mul",     ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        run("mulhu",   ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run("mulhsu",  ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2);
        run("mulh",    ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
        run("div",     ALU_DIV,    -32'sd20,     32'd6,        32'hFFFFFFFD, 34);
        run("rem",     ALU_REM,    -32'sd20,     32'd6,        32'hFFFFFFFE, 34);
        run("divu",    ALU_DIVU,   32'd100,      32'd7,        32'd14,       34);
        run("remu",    ALU_REMU,   32'd100,      32'd7,        32'd2,        34);
        run("divneg",  ALU_DIV,    32'd20,       -32'sd6,      32'hFFFFFFFD, 34);
        run("div0",    ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2);
        run("rem0",    ALU_REM,    32'd5,        32'd0,        32'd5,        2);
        run("remu0",   ALU_REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 2);
        run("ovfdiv",  ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run("ovfrem",  ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

        accept(5'b00000, 32'd3, 32'd4);
        chk("bad_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("bad_done", {31'b0, done}, 32'd0);
        chk("bad_res", result, last_res);

        issue("ign", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = ALU_MUL;
        src_a    = 32'd7;
        src_b    = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges++;
        wait_done("ign");
        pulse_end("ign");

        accept(ALU_DIV, -32'sd20, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        kill  = 1'b0;
        start = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("kill_nodone", {31'b0, seen}, 32'd0);
        chk("kill_res", result, last_res);

        issue("b2b_div", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
        wait_done("b2b_div");
        start    = 1'b1;
        alu_ctrl = ALU_MUL;
        src_a    = 32'd7;
        src_b    = 32'hFFFFFFFD;
        exp_q.push_back(32'hFFFFFFEB);
        lat_q.push_back(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        chk("b2b_div_pulse", {31'b0, done}, 32'd0);
        chk("b2b_mul_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_mul");
        pulse_end("b2b_mul");

        accept(ALU_DIV, -32'sd20, 32'd6);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_res", result, 32'd0);
        reset_n = 1'b1;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle execution unit for the RV32M instructions (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
- Sits in the execute stage beside the single-cycle ALU.
- Consumes the 5-bit alu_ctrl code produced by the ALU decoder plus the two register operands, and returns a 32-bit result with a done pulse.
- The datapath stalls on busy; the result is written to the register file on done.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is sized $clog2(XLEN)+1.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  request; sampled only when busy=0
- kill  input  1  abort the in-flight operation (pipeline flush)
- alu_ctrl  input  5  operation code: mul=01110, mulh=01111, mulhsu=10000, mulhu=10001, div=10010, divu=10011, rem=10100, remu=10101
- src_a  input  XLEN  rs1 value (multiplicand / dividend)
- src_b  input  XLEN  rs2 value (multiplier / divisor)
- busy  output  1  unit occupied (state != IDLE)
- done  output  1  single-cycle pulse, result valid
- result  output  XLEN  registered result, held until the next done

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0. This is also the required response to reset mid-operation; no done pulse is produced.
- Acceptance: at an edge with state=IDLE, start=1, and alu_ctrl one of the 8 M-codes, latch the operands and opcode.
  - start with any other alu_ctrl is ignored: stays IDLE, no done.
  - start while busy=1 is ignored.
- States: IDLE, MUL, DIV, FIX.
- Multiply path: IDLE -> MUL (1 cycle, 33x33 signed product registered) -> IDLE.
  - At the IDLE return edge: result = product[31:0] for mul, product[63:32] for the mulh variants; done=1.
  - Operand extension: mulh signed x signed; mulhsu signed src_a x unsigned src_b; mulhu unsigned x unsigned. Extension is to 33 bits by sign or zero.
  - Latency: done is high in the cycle after the 2nd edge following acceptance.
- Divide path: IDLE -> DIV -> FIX -> IDLE.
  - Signed ops (div, rem) take absolute values at acceptance.
  - DIV performs exactly 32 restoring shift-subtract steps, one per edge; the counter counts 0..31.
  - FIX applies sign correction: quotient is negated if the operand signs differ; remainder takes the dividend's sign. It registers the result and sets done=1.
  - Latency: 34 edges from acceptance to the done cycle.
- Special cases are detected at acceptance and bypass DIV; they go via FIX only (latency 2):
  - divisor=0: div/divu -> 0xFFFFFFFF; rem/remu -> dividend.
  - Signed overflow (div/rem with src_a=0x80000000, src_b=0xFFFFFFFF): div -> 0x80000000; rem -> 0.
- done is asserted for exactly one cycle; busy=0 in that same cycle.
- Back-to-back: a start in the done cycle is accepted at the next edge.
- kill=1 at any edge: state -> IDLE, no done, result unchanged. kill has priority over start in the same cycle; both high means nothing is accepted.
- reset_n has priority over kill.
- result only changes on done edges.
- Arithmetic is modulo 2^XLEN; no exceptions are raised.

Decomposition:
- Package muldiv_pkg:
  - localparams for the 8 alu_ctrl M-codes (shared with the ALU decoder);
  - typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;
  - helper function is_m_op(alu_ctrl).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: the next remainder and quotient.
- muldiv_unit holds the FSM, counter, operand/sign registers, multiplier and output registers.

Test Plan:
- mul: src_a=7, src_b=-3 (0xFFFFFFFD) -> done 2 cycles after accept, result=0xFFFFFFEB. mulhu with src_a=src_b=0xFFFFFFFF -> result=0xFFFFFFFE. mulhsu with src_a=-1, src_b=2 -> result=0xFFFFFFFF.
- div=-20 / 6 -> done at cycle 34, result=0xFFFFFFFD. The same operands with rem -> result=0xFFFFFFFE. divu 100/7 -> 14; remu 100/7 -> 2.
- Divide by zero:
  - div 5/0 -> result=0xFFFFFFFF, latency 2;
  - rem 5/0 -> result=5.
- Overflow:
  - div 0x80000000/0xFFFFFFFF -> 0x80000000;
  - rem of the same operands -> 0;
  - both with latency 2.
- Control:
  - start with alu_ctrl=00000 -> no busy, no done.
  - start during busy -> ignored, first result intact.
  - kill at DIV iteration 10 -> IDLE next cycle, no done, result unchanged.
  - reset_n=0 mid-DIV -> all outputs 0 next cycle.
- Back-to-back: mul issued in the done cycle of a div -> accepted. Two done pulses, one cycle each, correct results for both.
